// File: rtl/sar_search_if.sv
// Handshake and comparator bundle between a SAR search controller and its environment.
// The slave side is the controller. The master side supplies start and the comparator result.
interface sar_search_if #(
    parameter int unsigned W = 64
);
    logic         start;
    logic         cmp_ge;
    logic [W-1:0] trial;
    logic         busy;
    logic         done;
    logic [W-1:0] result;

    modport master (
        output start,
        output cmp_ge,
        input  trial,
        input  busy,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  cmp_ge,
        output trial,
        output busy,
        output done,
        output result
    );
endinterface

// File: rtl/sar_search.sv
// Successive-approximation search: builds the largest X with A >= X, MSB first, over W cycles
// by driving trial candidates into an external comparator and sampling its cmp_ge result.
module sar_search #(
    parameter int unsigned W = 64
) (
    input logic         clk,
    input logic         rst,
    sar_search_if.slave bus
);
    localparam int unsigned IW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        TRIAL = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  result_q, result_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [W-1:0]  bit_mask;

    assign bit_mask   = W'(1) << idx_q;
    assign bus.trial  = (state_q == TRIAL) ? (acc_q | bit_mask) : '0;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

    // Next-state logic; cmp_ge is only consulted while a trial is on the bus.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    idx_d   = IW'(W - 1);
                    busy_d  = 1'b1;
                    state_d = TRIAL;
                end
            end
            TRIAL: begin
                if (bus.cmp_ge) begin
                    acc_d = acc_q | bit_mask;
                end
                if (idx_q != '0) begin
                    idx_d = IW'(idx_q - IW'(1));
                end else begin
                    result_d = acc_d;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            idx_q    <= IW'(W - 1);
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end
endmodule
